// File: rtl/common_pkg.sv
// Shared cache-bus types used by every bus master, slave and arbiter in the slice.
package common;

   typedef enum logic [1:0] {
      MLEN1 = 2'd0,
      MLEN2 = 2'd1,
      MLEN4 = 2'd2,
      MLEN8 = 2'd3
   } mlen_t;

   typedef enum logic [1:0] {
      MSIZE_B = 2'd0,
      MSIZE_H = 2'd1,
      MSIZE_W = 2'd2,
      MSIZE_D = 2'd3
   } msize_t;

   // A master holds valid for the whole burst; a beat transfers on a rising
   // edge where the memory side presents ready, and last marks the final beat.
   typedef struct packed {
      logic        valid;
      logic        write;
      logic [31:0] addr;
      mlen_t       len;
      msize_t      size;
      logic [31:0] wdata;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] rdata;
   } cbus_resp_t;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   // Index width for n masters, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cbus_arbiter_rr_pick.sv
// Combinational winner search: first set bit of req_vec at or after ptr, wrapping modulo N.
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req_vec,
   input  logic [IW-1:0] ptr,
   output logic          any,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest valid one is assigned last.
   always_comb begin
      any  = 1'b0;
      idx  = '0;
      cand = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (int'(ptr) + j >= N) cand = IW'(int'(ptr) + j - N);
         else                    cand = IW'(int'(ptr) + j);
         if (req_vec[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/cbus_arbiter_rr.sv
// Cache-bus arbiter: grants one master a whole burst, round-robin or fixed priority,
// with one IDLE arbitration cycle between bursts.
module cbus_arbiter_rr
   import common::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int FIXED_PRIO  = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  cbus_req_t  [NUM_MASTERS-1:0]  ireqs,
   output cbus_resp_t [NUM_MASTERS-1:0]  iresps,
   output cbus_req_t                     oreq,
   input  cbus_resp_t                    oresp,
   output logic                          busy,
   output logic [2:0]                    grant_idx
);

   localparam int IW = idx_width(NUM_MASTERS);

   arb_state_t             state_q, state_d;
   logic [IW-1:0]          owner_q, owner_d;
   logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]          pick_ptr, pick_idx;
   logic                   pick_any;
   logic                   done;
   logic [NUM_MASTERS-1:0] valid_vec;

   for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_valid
      assign valid_vec[g] = ireqs[g].valid;
   end

   assign done     = oresp.ready & oresp.last;
   assign pick_ptr = (FIXED_PRIO != 0) ? '0 : rr_ptr_q;

   rr_pick #(
      .N  (NUM_MASTERS),
      .IW (IW)
   ) u_pick (
      .req_vec (valid_vec),
      .ptr     (pick_ptr),
      .any     (pick_any),
      .idx     (pick_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ARB_IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Outputs depend only on registered ownership, so reset clears them without a clock.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_ptr_d  = rr_ptr_q;
      oreq      = '0;
      iresps    = '0;
      busy      = 1'b0;
      grant_idx = 3'd0;
      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               state_d = ARB_BUSY;
               owner_d = pick_idx;
            end
         end
         ARB_BUSY: begin
            oreq            = ireqs[owner_q];
            iresps[owner_q] = oresp;
            busy            = 1'b1;
            grant_idx       = 3'(owner_q);
            if (done) begin
               state_d = ARB_IDLE;
               if (FIXED_PRIO == 0) begin
                  rr_ptr_d = (owner_q == IW'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cbus_arbiter_rr.sv
// Bench for cbus_arbiter_rr: three configurations (2 RR, 4 RR, 4 fixed) against a
// burst-level ownership model, plus hand-computed expectations per scenario.
module tb_cbus_arbiter_rr;
   import common::*;

   localparam int NI = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   cbus_req_t  [3:0] reqs [NI];
   cbus_resp_t       resp_in [NI];

   cbus_resp_t [1:0] resps_a;
   cbus_resp_t [3:0] resps_b, resps_c;
   cbus_req_t        oreq_a, oreq_b, oreq_c;
   logic             busy_a, busy_b, busy_c;
   logic [2:0]       gidx_a, gidx_b, gidx_c;

   int checks = 0;
   int errors = 0;

   int m_busy [NI];
   int m_owner [NI];
   int m_ptr [NI];
   int idle_run [NI];
   int glog [NI][$];
   int gaps [NI][$];
   int exp_order [5] = '{0, 1, 2, 3, 0};

   always #5 clk = ~clk;

   cbus_arbiter_rr #(.NUM_MASTERS(2), .FIXED_PRIO(0)) u_a (
      .clk(clk), .rst_n(rst_n), .ireqs(reqs[0][1:0]), .iresps(resps_a),
      .oreq(oreq_a), .oresp(resp_in[0]), .busy(busy_a), .grant_idx(gidx_a));

   cbus_arbiter_rr #(.NUM_MASTERS(4), .FIXED_PRIO(0)) u_b (
      .clk(clk), .rst_n(rst_n), .ireqs(reqs[1]), .iresps(resps_b),
      .oreq(oreq_b), .oresp(resp_in[1]), .busy(busy_b), .grant_idx(gidx_b));

   cbus_arbiter_rr #(.NUM_MASTERS(4), .FIXED_PRIO(1)) u_c (
      .clk(clk), .rst_n(rst_n), .ireqs(reqs[2]), .iresps(resps_c),
      .oreq(oreq_c), .oresp(resp_in[2]), .busy(busy_c), .grant_idx(gidx_c));

   function automatic int n_of(input int k);
      return (k == 0) ? 2 : 4;
   endfunction

   function automatic bit fixed_of(input int k);
      return (k == 2);
   endfunction

   function automatic logic act_busy(input int k);
      case (k)
         0:       return busy_a;
         1:       return busy_b;
         default: return busy_c;
      endcase
   endfunction

   function automatic logic [2:0] act_gidx(input int k);
      case (k)
         0:       return gidx_a;
         1:       return gidx_b;
         default: return gidx_c;
      endcase
   endfunction

   function automatic cbus_req_t act_oreq(input int k);
      case (k)
         0:       return oreq_a;
         1:       return oreq_b;
         default: return oreq_c;
      endcase
   endfunction

   function automatic cbus_resp_t act_resp(input int k, input int i);
      case (k)
         0:       return resps_a[i];
         1:       return resps_b[i];
         default: return resps_c[i];
      endcase
   endfunction

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         m_busy[k]   = 0;
         m_owner[k]  = 0;
         m_ptr[k]    = 0;
         idle_run[k] = 0;
      end
   endtask

   // One burst owner at a time; idle edges pick the first valid master from the pointer.
   task automatic model_step();
      int n, win, start, idx;
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int k = 0; k < NI; k++) begin
         n = n_of(k);
         if (m_busy[k] == 0) begin
            idle_run[k]++;
            win   = -1;
            start = fixed_of(k) ? 0 : m_ptr[k];
            for (int j = 0; j < n; j++) begin
               idx = (start + j) % n;
               if (win < 0 && reqs[k][idx].valid) win = idx;
            end
            if (win >= 0) begin
               m_busy[k]  = 1;
               m_owner[k] = win;
               glog[k].push_back(win);
               gaps[k].push_back(idle_run[k]);
            end
         end else if (resp_in[k].ready && resp_in[k].last) begin
            m_busy[k]   = 0;
            idle_run[k] = 0;
            if (!fixed_of(k)) m_ptr[k] = (m_owner[k] + 1) % n;
         end
      end
   endtask

   task automatic compare_all();
      cbus_resp_t e;
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("busy%0d", k), 80'(act_busy(k)), 80'(m_busy[k] != 0));
         if (m_busy[k] != 0) begin
            chk($sformatf("gidx%0d", k), 80'(act_gidx(k)), 80'(m_owner[k]));
            chk($sformatf("oreq%0d", k), 80'(act_oreq(k)), 80'(reqs[k][m_owner[k]]));
         end else begin
            chk($sformatf("oreq_idle%0d", k), 80'(act_oreq(k)), '0);
         end
         for (int i = 0; i < n_of(k); i++) begin
            e = (m_busy[k] != 0 && i == m_owner[k]) ? resp_in[k] : '0;
            chk($sformatf("iresp%0d_%0d", k, i), 80'(act_resp(k, i)), 80'(e));
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic wait_grant(input int k, input string name);
      int n;
      n = 0;
      while (!act_busy(k) && n < 20) begin
         tick();
         n++;
      end
      chk({name, "_grant_seen"}, 80'(act_busy(k)), 80'(1'b1));
   endtask

   task automatic run_beats(input int k, input int beats, input int base);
      for (int b = 0; b < beats; b++) begin
         resp_in[k] = '{ready: 1'b1, last: (b == beats - 1), rdata: 32'(base + b)};
         tick();
      end
      resp_in[k] = '0;
   endtask

   task automatic chk_resps_b_zero(input string name);
      for (int i = 0; i < 4; i++) chk(name, 80'(resps_b[i]), '0);
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         reqs[k]    = '0;
         resp_in[k] = '0;
      end
      model_reset();

      // Reset: outputs quiet even with a request and a completing response present.
      tick();
      reqs[1][0].valid = 1'b1;
      resp_in[1]       = '{ready: 1'b1, last: 1'b1, rdata: 32'h1234_5678};
      #1;
      chk("rst_busy", 80'(busy_b), 80'(1'b0));
      chk("rst_gidx", 80'(gidx_b), 80'(3'd0));
      chk("rst_oreq", 80'(oreq_b), '0);
      chk_resps_b_zero("rst_iresp");
      tick();
      chk("rst_busy_after_edge", 80'(busy_b), 80'(1'b0));
      reqs[1]    = '0;
      resp_in[1] = '0;
      rst_n      = 1'b1;
      tick();

      // Single master read burst on the two-master arbiter.
      reqs[0][0] = '{valid: 1'b1, write: 1'b0, addr: 32'h8000_0000, len: MLEN4,
                     size: MSIZE_W, wdata: 32'h0};
      #1;
      chk("s1_idle_busy", 80'(busy_a), 80'(1'b0));
      chk("s1_idle_oreq", 80'(oreq_a), '0);
      tick();
      chk("s1_grant_busy", 80'(busy_a), 80'(1'b1));
      chk("s1_grant_idx", 80'(gidx_a), 80'(3'd0));
      chk("s1_oreq_addr", 80'(oreq_a.addr), 80'(32'h8000_0000));
      for (int b = 0; b < 4; b++) begin
         resp_in[0] = '{ready: 1'b1, last: (b == 3), rdata: 32'h100 + 32'(b)};
         #1;
         chk("s1_beat_data", 80'(resps_a[0].rdata), 80'(32'h100 + 32'(b)));
         chk("s1_beat_last", 80'(resps_a[0].last), 80'(b == 3));
         chk("s1_other_zero", 80'(resps_a[1]), '0);
         tick();
      end
      resp_in[0] = '0;
      reqs[0]    = '0;
      #1;
      chk("s1_done_idle", 80'(busy_a), 80'(1'b0));

      // Stray completing response while idle goes nowhere.
      resp_in[0] = '{ready: 1'b1, last: 1'b1, rdata: 32'hDEAD_BEEF};
      #1;
      chk("stray_r0", 80'(resps_a[0]), '0);
      chk("stray_r1", 80'(resps_a[1]), '0);
      tick();
      chk("stray_busy", 80'(busy_a), 80'(1'b0));
      chk("stray_r0_edge", 80'(resps_a[0]), '0);
      resp_in[0] = '0;
      // Pointer moved to 1 after m0's burst and the stray beat left it there.
      reqs[0][0].valid = 1'b1;
      reqs[0][1]       = '{valid: 1'b1, write: 1'b1, addr: 32'h8000_0040, len: MLEN1,
                           size: MSIZE_W, wdata: 32'h55};
      tick();
      chk("stray_ptr_kept", 80'(gidx_a), 80'(3'd1));
      run_beats(0, 1, 0);
      reqs[0] = '0;
      tick();

      // Round-robin contention: four masters, two-beat bursts.
      glog[1].delete();
      gaps[1].delete();
      for (int i = 0; i < 4; i++) begin
         reqs[1][i] = '{valid: 1'b1, write: 1'b0, addr: 32'h1000 * 32'(i), len: MLEN2,
                        size: MSIZE_W, wdata: 32'h0};
      end
      for (int g = 0; g < 5; g++) begin
         wait_grant(1, "s2");
         chk("s2_order_dut", 80'(gidx_b), 80'(exp_order[g]));
         run_beats(1, 2, g * 16);
      end
      reqs[1] = '0;
      chk("s2_log_len", 80'(glog[1].size()), 80'(5));
      for (int g = 0; g < glog[1].size() && g < 5; g++) begin
         chk("s2_order_model", 80'(glog[1][g]), 80'(exp_order[g]));
         if (g > 0) chk("s2_one_idle", 80'(gaps[1][g]), 80'(1));
      end
      tick();

      // Intrusion: m1 owns an 8-beat write, m0 raises valid at beat 3.
      reqs[1][1] = '{valid: 1'b1, write: 1'b1, addr: 32'h2000_0000, len: MLEN8,
                     size: MSIZE_W, wdata: 32'hA5A5_0000};
      wait_grant(1, "s3");
      chk("s3_owner", 80'(gidx_b), 80'(3'd1));
      for (int b = 0; b < 8; b++) begin
         if (b == 2) reqs[1][0] = '{valid: 1'b1, write: 1'b0, addr: 32'h3000_0000,
                                    len: MLEN1, size: MSIZE_W, wdata: 32'h0};
         reqs[1][1].valid = (b != 4);
         reqs[1][1].wdata = 32'hA5A5_0000 + 32'(b);
         resp_in[1] = '{ready: 1'b1, last: (b == 7), rdata: 32'h0};
         #1;
         chk("s3_gidx", 80'(gidx_b), 80'(3'd1));
         chk("s3_busy", 80'(busy_b), 80'(1'b1));
         chk("s3_oreq_wdata", 80'(oreq_b.wdata), 80'(32'hA5A5_0000 + 32'(b)));
         chk("s3_oreq_valid", 80'(oreq_b.valid), 80'(b != 4));
         tick();
      end
      resp_in[1] = '0;
      reqs[1][1] = '0;
      #1;
      chk("s3_gap_busy", 80'(busy_b), 80'(1'b0));
      chk("s3_gap_oreq", 80'(oreq_b), '0);
      tick();
      chk("s3_m0_busy", 80'(busy_b), 80'(1'b1));
      chk("s3_m0_grant", 80'(gidx_b), 80'(3'd0));
      run_beats(1, 1, 0);
      reqs[1] = '0;
      tick();

      // Reset mid-burst: pointer sits at 1 here, so m1 would win if it survived reset.
      reqs[1][1] = '{valid: 1'b1, write: 1'b0, addr: 32'h4000_0000, len: MLEN4,
                     size: MSIZE_W, wdata: 32'h0};
      wait_grant(1, "s4");
      chk("s4_owner", 80'(gidx_b), 80'(3'd1));
      resp_in[1] = '{ready: 1'b1, last: 1'b0, rdata: 32'h1};
      tick();
      resp_in[1] = '{ready: 1'b1, last: 1'b0, rdata: 32'h2};
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("s4_rst_busy", 80'(busy_b), 80'(1'b0));
      chk("s4_rst_valid", 80'(oreq_b.valid), 80'(1'b0));
      chk("s4_rst_gidx", 80'(gidx_b), 80'(3'd0));
      chk_resps_b_zero("s4_rst_iresp");
      tick();
      resp_in[1] = '0;
      reqs[1][0] = '{valid: 1'b1, write: 1'b0, addr: 32'h5000_0000, len: MLEN1,
                     size: MSIZE_W, wdata: 32'h0};
      rst_n = 1'b1;
      #1;
      chk("s4_release_idle", 80'(busy_b), 80'(1'b0));
      tick();
      chk("s4_first_busy", 80'(busy_b), 80'(1'b1));
      chk("s4_first_m0", 80'(gidx_b), 80'(3'd0));
      run_beats(1, 1, 0);
      reqs[1] = '0;
      tick();

      // Fixed priority: m0 beats m2 unless m0 is idle in the arbitration cycle.
      reqs[2][0] = '{valid: 1'b1, write: 1'b0, addr: 32'h6000_0000, len: MLEN1,
                     size: MSIZE_W, wdata: 32'h0};
      reqs[2][2] = '{valid: 1'b1, write: 1'b1, addr: 32'h6200_0000, len: MLEN1,
                     size: MSIZE_W, wdata: 32'h77};
      tick();
      chk("s5_g1", 80'(gidx_c), 80'(3'd0));
      run_beats(2, 1, 0);
      tick();
      chk("s5_g2", 80'(gidx_c), 80'(3'd0));
      run_beats(2, 1, 0);
      reqs[2][0].valid = 1'b0;
      tick();
      chk("s5_g3_busy", 80'(busy_c), 80'(1'b1));
      chk("s5_g3", 80'(gidx_c), 80'(3'd2));
      reqs[2][0].valid = 1'b1;
      run_beats(2, 1, 0);
      tick();
      chk("s5_g4", 80'(gidx_c), 80'(3'd0));
      run_beats(2, 1, 0);
      reqs[2] = '0;
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
